// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared LSU definitions: FSM state encoding, Funct3 load/store codes, bus response
// codes and store-lane helpers. Also provides the default `DATA_WIDTH.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ysyx_23060184_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } store_lane_t;

  // Narrow stores replicate their data across every lane so the strobe alone
  // selects the destination bytes.
  function automatic store_lane_t store_lanes(input logic [2:0]  funct3,
                                              input logic [1:0]  offset,
                                              input logic [31:0] wdata);
    store_lane_t lane;
    lane.strb = 4'b0000;
    lane.data = wdata;
    case (funct3)
      F3_SB: begin
        lane.strb = 4'b0001 << offset;
        lane.data = {4{wdata[7:0]}};
      end
      F3_SH: begin
        lane.strb = 4'b0011 << {offset[1], 1'b0};
        lane.data = {2{wdata[15:0]}};
      end
      F3_SW:   lane.strb = 4'b1111;
      default: lane.strb = 4'b0000;
    endcase
    return lane;
  endfunction

  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic half;
    logic word;
    half = (funct3 == F3_LH) || (is_load && (funct3 == F3_LHU));
    word = (funct3 == F3_LW);
    return (half && offset[0]) || (word && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_if.sv
// Memory-side bus of the LSU: independent read (ar/r) and write (aw/w/b) channels.
interface ysyx_23060184_lsu_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_23060184_LoadExt.sv
// Load extraction: picks the byte/halfword addressed by the low address bits from
// the returned bus word and sign- or zero-extends it according to Funct3.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ysyx_23060184_LoadExt
  import ysyx_23060184_lsu_pkg::*;
(
  input  logic [2:0]             funct3_i,
  input  logic [1:0]             offset_i,
  input  logic [31:0]            rdata_i,
  output logic [`DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    // NOTE: the default assignment ahead of the case keeps every path driven, so
    // unlisted Funct3 codes read as zero instead of inferring a latch.
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = `DATA_WIDTH'($signed(byte_sel));
      F3_LBU:  data_o = `DATA_WIDTH'(byte_sel);
      F3_LH:   data_o = `DATA_WIDTH'($signed(half_sel));
      F3_LHU:  data_o = `DATA_WIDTH'(half_sel);
      F3_LW:   data_o = `DATA_WIDTH'($signed(rdata_i));
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: accepts one request at a time, runs it on the ar/r or aw/w/b bus
// and holds the extended result until taken. Optional YSYX_23060184_LSU_MISALIGN_CHECK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ysyx_23060184_lsu
  import ysyx_23060184_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [2:0]             Funct3,
  input  logic [ADDR_W-1:0]      Addr,
  input  logic [`DATA_WIDTH-1:0] WData,

  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`DATA_WIDTH-1:0] ReadData,
  output logic                   LsuErr,

  ysyx_23060184_lsu_if.master    bus
);

  lsu_state_e             state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [2:0]             funct3_q;
  logic [31:0]            wdata_q;
  logic [3:0]             wstrb_q;
  logic                   arvalid_q;
  logic                   rready_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   bready_q;
  logic                   out_valid_q;
  logic [`DATA_WIDTH-1:0] read_data_q;
  logic                   err_q;

  store_lane_t            lane_d;
  logic [`DATA_WIDTH-1:0] load_ext_d;
  logic                   misalign_d;
  logic                   aw_done_d;
  logic                   w_done_d;

  assign lane_d = store_lanes(Funct3, Addr[1:0], WData[31:0]);

`ifdef YSYX_23060184_LSU_MISALIGN_CHECK_EN
  assign misalign_d = (MemRead || MemWrite) && is_misaligned(MemRead, Funct3, Addr[1:0]);
`else
  assign misalign_d = 1'b0;
`endif

  // Each write channel counts as finished once its valid has already dropped or
  // is being accepted this cycle, so same-cycle completion moves straight on.
  assign aw_done_d = !awvalid_q || bus.awready;
  assign w_done_d  = !wvalid_q  || bus.wready;

  ysyx_23060184_LoadExt u_load_ext (
    .funct3_i (funct3_q),
    .offset_i (addr_q[1:0]),
    .rdata_i  (bus.rdata),
    .data_o   (load_ext_d)
  );

  // NOTE: every register here uses non-blocking assignment so all of them update
  // together from values sampled before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      out_valid_q <= 1'b0;
      read_data_q <= '0;
      err_q       <= 1'b0;
      wstrb_q     <= 4'b0000;
      // NOTE: addr_q, funct3_q and wdata_q are payload registers that are always
      // loaded on acceptance before use, so they are deliberately left unreset.
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            addr_q   <= Addr;
            funct3_q <= Funct3;
            wdata_q  <= lane_d.data;
            wstrb_q  <= 4'b0000;
            if (misalign_d) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              read_data_q <= '0;
              err_q       <= 1'b1;
            end else if (MemRead) begin
              state_q   <= RADDR;
              arvalid_q <= 1'b1;
            end else if (MemWrite) begin
              state_q   <= WREQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              wstrb_q   <= lane_d.strb;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              read_data_q <= '0;
              err_q       <= 1'b0;
            end
          end
        end

        RADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end

        RDATA: begin
          if (bus.rvalid) begin
            rready_q    <= 1'b0;
            read_data_q <= load_ext_d;
            err_q       <= (bus.rresp != RESP_OKAY);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        WREQ: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end

        WRESP: begin
          if (bus.bvalid) begin
            bready_q    <= 1'b0;
            read_data_q <= '0;
            err_q       <= (bus.bresp != RESP_OKAY);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign ReadData    = read_data_q;
  assign LsuErr      = err_q;

  assign bus.araddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.awvalid = awvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_q;
  assign bus.bready  = bready_q;

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed self-checking bench for ysyx_23060184_lsu; the bench acts as bus slave
// and upstream/downstream stages with hand-computed expected values.
module tb_ysyx_23060184_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ReadData;
  logic        LsuErr;

  int checks = 0;
  int errors = 0;

  ysyx_23060184_lsu_if #(.ADDR_W(32)) bus ();

  ysyx_23060184_lsu #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .Addr      (Addr),
    .WData     (WData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ReadData  (ReadData),
    .LsuErr    (LsuErr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
    Addr = 32'h0; WData = 32'h0; out_ready = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    repeat (3) cyc();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, out_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset valids ar/r/aw/w/b/out: got %b expected 000000",
               {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, out_valid});
    end
    checks++;
    if ({ReadData, LsuErr, bus.wstrb} !== 37'h0) begin
      errors++;
      $display("FAIL reset data: ReadData=%h LsuErr=%b wstrb=%b expected all zero",
               ReadData, LsuErr, bus.wstrb);
    end
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic both, input logic [31:0] rd, input logic [1:0] resp,
                         input logic [31:0] exp_data, input logic exp_err, input int stall);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = both; Funct3 = f3; Addr = addr;
    WData = 32'h5A5A_5A5A;
    cyc();
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, in_ready} !== 4'b1000) begin
      errors++; $display("FAIL %s raddr ar/aw/w/in_ready: got %b expected 1000", name,
                         {bus.arvalid, bus.awvalid, bus.wvalid, in_ready});
    end
    checks++;
    if (bus.araddr !== exp_addr) begin
      errors++; $display("FAIL %s araddr: got %h expected %h", name, bus.araddr, exp_addr);
    end
    bus.arready = 1'b1;
    cyc();
    bus.arready = 1'b0;
    checks++;
    if ({bus.arvalid, bus.rready, out_valid} !== 3'b010) begin
      errors++; $display("FAIL %s rdata ar/r/out: got %b expected 010", name,
                         {bus.arvalid, bus.rready, out_valid});
    end
    bus.rvalid = 1'b1; bus.rdata = rd; bus.rresp = resp;
    cyc();
    bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    checks++;
    if ({out_valid, bus.rready, in_ready} !== 3'b100) begin
      errors++; $display("FAIL %s done out/r/in_ready: got %b expected 100", name,
                         {out_valid, bus.rready, in_ready});
    end
    checks++;
    if (ReadData !== exp_data) begin
      errors++; $display("FAIL %s ReadData: got %h expected %h", name, ReadData, exp_data);
    end
    checks++;
    if (LsuErr !== exp_err) begin
      errors++; $display("FAIL %s LsuErr: got %b expected %b", name, LsuErr, exp_err);
    end
    for (int i = 0; i < stall; i++) begin
      cyc();
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || ReadData !== exp_data || LsuErr !== exp_err) begin
        errors++; $display("FAIL %s stall %0d: out_valid=%b in_ready=%b ReadData=%h expected 1 0 %h",
                           name, i, out_valid, in_ready, ReadData, exp_data);
      end
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s release out/in_ready: got %b expected 01", name,
                         {out_valid, in_ready});
    end
  endtask

  task automatic do_store(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input int aw_at, input int w_at,
                          input logic [1:0] resp, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic exp_err);
    logic [31:0] exp_addr;
    int          last;
    exp_addr = {addr[31:2], 2'b00};
    last = (aw_at > w_at) ? aw_at : w_at;
    in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = f3; Addr = addr; WData = wd;
    cyc();
    in_valid = 1'b0; MemWrite = 1'b0;
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, in_ready} !== 4'b1100) begin
      errors++; $display("FAIL %s wreq aw/w/ar/in_ready: got %b expected 1100", name,
                         {bus.awvalid, bus.wvalid, bus.arvalid, in_ready});
    end
    checks++;
    if (bus.awaddr !== exp_addr) begin
      errors++; $display("FAIL %s awaddr: got %h expected %h", name, bus.awaddr, exp_addr);
    end
    checks++;
    if (bus.wstrb !== exp_strb) begin
      errors++; $display("FAIL %s wstrb: got %b expected %b", name, bus.wstrb, exp_strb);
    end
    checks++;
    if (bus.wdata !== exp_wdata) begin
      errors++; $display("FAIL %s wdata: got %h expected %h", name, bus.wdata, exp_wdata);
    end
    for (int k = 1; k <= last; k++) begin
      checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready} !== {(k <= aw_at), (k <= w_at), 1'b0}) begin
        errors++; $display("FAIL %s handshake cycle %0d aw/w/b: got %b expected %b", name, k,
                           {bus.awvalid, bus.wvalid, bus.bready},
                           {(k <= aw_at), (k <= w_at), 1'b0});
      end
      bus.awready = (k == aw_at);
      bus.wready  = (k == w_at);
      cyc();
    end
    bus.awready = 1'b0; bus.wready = 1'b0;
    checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, out_valid} !== 4'b0010) begin
      errors++; $display("FAIL %s wresp aw/w/b/out: got %b expected 0010", name,
                         {bus.awvalid, bus.wvalid, bus.bready, out_valid});
    end
    bus.bvalid = 1'b1; bus.bresp = resp;
    cyc();
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    checks++;
    if ({out_valid, bus.bready} !== 2'b10) begin
      errors++; $display("FAIL %s done out/b: got %b expected 10", name, {out_valid, bus.bready});
    end
    checks++;
    if (LsuErr !== exp_err) begin
      errors++; $display("FAIL %s LsuErr: got %b expected %b", name, LsuErr, exp_err);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({out_valid, in_ready, bus.bready} !== 3'b010) begin
      errors++; $display("FAIL %s single pulse out/in_ready/b: got %b expected 010", name,
                         {out_valid, in_ready, bus.bready});
    end
  endtask

  task automatic test_loads();
    do_load("lb_b3",   32'h8000_0003, 3'b000, 1'b0, 32'h80FF_FF00, 2'b00, 32'hFFFF_FF80, 1'b0, 0);
    do_load("lbu_b3",  32'h8000_0003, 3'b100, 1'b0, 32'h80FF_FF00, 2'b00, 32'h0000_0080, 1'b0, 0);
    do_load("lb_b1",   32'h8000_0001, 3'b000, 1'b0, 32'h1234_5678, 2'b00, 32'h0000_0056, 1'b0, 0);
    do_load("lbu_b2",  32'h8000_0002, 3'b100, 1'b0, 32'h80FF_FF00, 2'b00, 32'h0000_00FF, 1'b0, 0);
    do_load("lh_h1",   32'h8000_0002, 3'b001, 1'b0, 32'h80FF_FF00, 2'b00, 32'hFFFF_80FF, 1'b0, 0);
    do_load("lhu_h1",  32'h8000_0002, 3'b101, 1'b0, 32'h80FF_FF00, 2'b00, 32'h0000_80FF, 1'b0, 0);
    do_load("lh_h0",   32'h8000_0000, 3'b001, 1'b0, 32'h80FF_FF00, 2'b00, 32'hFFFF_FF00, 1'b0, 0);
    do_load("lw",      32'h8000_0004, 3'b010, 1'b0, 32'h80FF_FF00, 2'b00, 32'h80FF_FF00, 1'b0, 0);
    do_load("f3_011",  32'h8000_0000, 3'b011, 1'b0, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, 1'b0, 0);
    do_load("rd_prio", 32'h8000_0008, 3'b010, 1'b1, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1'b0, 0);
  endtask

  task automatic test_nonmem();
    in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h8000_0000;
    cyc();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, bus.arvalid, bus.awvalid, bus.wvalid, in_ready} !== 5'b10000) begin
      errors++; $display("FAIL nonmem out/ar/aw/w/in_ready: got %b expected 10000",
                         {out_valid, bus.arvalid, bus.awvalid, bus.wvalid, in_ready});
    end
    checks++;
    if ({ReadData, LsuErr} !== 33'h0) begin
      errors++; $display("FAIL nonmem data: ReadData=%h LsuErr=%b expected 0 0", ReadData, LsuErr);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL nonmem release out/in_ready: got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_stores();
    do_store("sh_h1", 32'h8000_0002, 3'b001, 32'h1234_ABCD, 1, 1, 2'b00, 4'b1100, 32'hABCD_ABCD, 1'b0);
    do_store("sb_b1", 32'h8000_0001, 3'b000, 32'h0000_00A5, 1, 1, 2'b00, 4'b0010, 32'hA5A5_A5A5, 1'b0);
    do_store("sb_b3", 32'h8000_0003, 3'b000, 32'hFFFF_FF3C, 1, 1, 2'b00, 4'b1000, 32'h3C3C_3C3C, 1'b0);
    do_store("sh_h0", 32'h8000_0000, 3'b001, 32'h0000_7E01, 1, 1, 2'b00, 4'b0011, 32'h7E01_7E01, 1'b0);
  endtask

  task automatic test_split_handshake();
    do_store("sw_aw1_w4", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 1, 4, 2'b00, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    do_store("sw_aw3_w1", 32'h8000_000C, 3'b010, 32'h0102_0304, 3, 1, 2'b00, 4'b1111, 32'h0102_0304, 1'b0);
    do_store("sw_aw2_w2", 32'h8000_0010, 3'b010, 32'hCAFE_0001, 2, 2, 2'b00, 4'b1111, 32'hCAFE_0001, 1'b0);
  endtask

  task automatic test_errors();
    do_store("sw_bresp_err", 32'h8000_0020, 3'b010, 32'h5555_AAAA, 1, 1, 2'b11, 4'b1111, 32'h5555_AAAA, 1'b1);
    do_load("lw_rresp_err", 32'h8000_0024, 3'b010, 1'b0, 32'hA5A5_0001, 2'b10, 32'hA5A5_0001, 1'b1, 0);
  endtask

  task automatic test_out_ready_stall();
    do_load("lw_stall", 32'h8000_0030, 3'b010, 1'b0, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 1'b0, 5);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h8000_0040;
    cyc();
    in_valid = 1'b0; MemRead = 1'b0;
    bus.arready = 1'b1;
    cyc();
    bus.arready = 1'b0;
    checks++;
    if (bus.rready !== 1'b1) begin
      errors++; $display("FAIL rstmid reach rdata rready: got %b expected 1", bus.rready);
    end
    rst = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D; bus.rresp = 2'b10;
    cyc();
    rst = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    checks++;
    if ({in_ready, bus.rready, out_valid, bus.arvalid} !== 4'b1000) begin
      errors++; $display("FAIL rstmid in_ready/r/out/ar: got %b expected 1000",
                         {in_ready, bus.rready, out_valid, bus.arvalid});
    end
    checks++;
    if ({ReadData, LsuErr} !== 33'h0) begin
      errors++; $display("FAIL rstmid data: ReadData=%h LsuErr=%b expected 0 0", ReadData, LsuErr);
    end
    cyc();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL rstmid discard out/in_ready: got %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_misalign();
`ifdef YSYX_23060184_LSU_MISALIGN_CHECK_EN
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h8000_0002;
    cyc();
    in_valid = 1'b0; MemRead = 1'b0;
    checks++;
    if ({out_valid, bus.arvalid, bus.awvalid, LsuErr} !== 4'b1001) begin
      errors++; $display("FAIL misalign lw out/ar/aw/err: got %b expected 1001",
                         {out_valid, bus.arvalid, bus.awvalid, LsuErr});
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; MemWrite = 1'b1; Funct3 = 3'b001; Addr = 32'h8000_0003; WData = 32'h0000_BEEF;
    cyc();
    in_valid = 1'b0; MemWrite = 1'b0;
    checks++;
    if ({out_valid, bus.arvalid, bus.awvalid, bus.wvalid, LsuErr} !== 5'b10001) begin
      errors++; $display("FAIL misalign sh out/ar/aw/w/err: got %b expected 10001",
                         {out_valid, bus.arvalid, bus.awvalid, bus.wvalid, LsuErr});
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
`else
    do_load("lw_misaligned", 32'h8000_0002, 3'b010, 1'b0, 32'h80FF_FF00, 2'b00, 32'h80FF_FF00, 1'b0, 0);
    do_store("sh_odd", 32'h8000_0003, 3'b001, 32'h0000_BEEF, 1, 1, 2'b00, 4'b1100, 32'hBEEF_BEEF, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_loads();
    test_nonmem();
    test_stores();
    test_split_handshake();
    test_errors();
    test_reset_mid();
    test_out_ready_stall();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
